// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg : mode and direction encodings plus the LED pattern helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_ASC  = 1'b0,
    DIR_DESC = 1'b1
  } dir_e;

  localparam int LED_MAX_W = 256;

  // Callers truncate the result to their own LED count.
  function automatic logic [LED_MAX_W-1:0] pattern(input int p, input bit active_low);
    logic [LED_MAX_W-1:0] v;
    for (int i = 0; i < LED_MAX_W; i++) begin
      v[i] = (i == p) ^ active_low;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_engine_tick_gen.sv
// ============================================================================
// tick_gen : single-clock divider emitting a one-cycle registered tick every
//            CLK_HZ/TICK_HZ cycles while enabled.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          last_w;

  assign last_w = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      cnt_d  = last_w ? '0 : cnt_q + CW'(1);
      tick_d = last_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/led_pattern_engine.sv
// ============================================================================
// led_pattern_engine : walks a single active LED (rotate / bounce / hold)
//                      stepping on each divided tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_pattern_engine
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int WIDTH      = 16,
  parameter int ACTIVE_LOW = 1,
  localparam int PW        = (WIDTH >= 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pause,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             tick
);

  generate
    if (WIDTH < 2 || WIDTH > LED_MAX_W) begin : g_width_check
      $error("led_pattern_engine: WIDTH out of range");
    end
  endgenerate

  logic             tick_w;
  logic             step_w;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick_w)
  );

  assign step_w = tick_w && !pause;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (step_w) begin
      case (mode_e'(mode))
        MODE_ROL: begin
          pos_d = (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);
          dir_d = DIR_ASC;
        end
        MODE_ROR: begin
          pos_d = (pos_q == '0) ? PW'(WIDTH - 1) : pos_q - PW'(1);
          dir_d = DIR_DESC;
        end
        MODE_BOUNCE: begin
          // Endpoints turn around immediately so neither end is shown twice.
          if (dir_q == DIR_ASC) begin
            if (pos_q == PW'(WIDTH - 1)) begin
              pos_d = PW'(WIDTH - 2);
              dir_d = DIR_DESC;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PW'(1);
              dir_d = DIR_ASC;
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        default: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
      endcase
    end
    led_d = WIDTH'(pattern(int'(pos_d), ACTIVE_LOW != 0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_ASC;
      led_q <= WIDTH'(pattern(0, ACTIVE_LOW != 0));
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      led_q <= led_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign tick = tick_w;

endmodule

`default_nettype wire

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised LED chaser for the board's LED bank. A single-clock-domain tick generator replaces a derived divided clock. The tick drives a position register that walks a single active LED in one of four modes: rotate-left, rotate-right, bounce, or hold. Sits between the top-level clk and the led/seg pins; seg drivers may reuse the led output sliced to 8 bits.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
TICK_HZ, 10, step rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 required (elaboration error otherwise)
WIDTH, 16, number of LEDs driven; WIDTH >= 2 required
ACTIVE_LOW, 1, 1 = active LED driven 0, all others 1; 0 = one-hot high

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = tick counter runs; 0 = counter held at 0, no ticks
pause  input  1  1 = ticks still emitted, position steps suppressed
mode  input  2  0 rotate-left, 1 rotate-right, 2 bounce, 3 hold
led  output  WIDTH  registered pattern
pos  output  $clog2(WIDTH)  index of active LED
dir  output  1  0 = ascending, 1 = descending
tick  output  1  one-cycle pulse per step period

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, tick=0, pos=0, dir=0, led=pattern(0). With ACTIVE_LOW=1 and WIDTH=16, led=16'hFFFE. rst overrides en, pause and tick.
- Tick gen: when en=1, cnt increments, wrapping DIV-1 -> 0. tick=1 in the cycle after cnt==DIV-1 is registered, so it is a registered pulse of exactly 1 cycle every DIV cycles. When en=0, cnt<=0 and tick<=0. Re-enabling gives the first tick DIV cycles later.
- Step: occurs on the edge where tick=1 and pause=0. pos, dir and led update on the same edge, so led always equals pattern(pos).
- mode 0: pos <= (pos==WIDTH-1) ? 0 : pos+1; dir <= 0.
- mode 1: pos <= (pos==0) ? WIDTH-1 : pos-1; dir <= 1.
- mode 2, dir=0: if pos==WIDTH-1 then pos<=WIDTH-2 and dir<=1; else pos<=pos+1.
- mode 2, dir=1: if pos==0 then pos<=1 and dir<=0; else pos<=pos-1. No endpoint is repeated.
- mode 3: pos and dir hold; led unchanged.
- pattern(p): bit p active, all other bits inactive, polarity per ACTIVE_LOW.
- mode is sampled only at the step edge. A mid-period mode change takes effect at the next step. Bounce entered from mode 0/1 continues in the direction left in dir.
- pause=1 on a tick edge: the step is lost, not deferred.
- pos arithmetic is width-safe for non-power-of-2 WIDTH. Wrap uses explicit compares, never modulo overflow.
- rst asserted mid-period discards the partial count; the next tick comes DIV cycles after rst deasserts (with en=1).

Decomposition:
- Shared package led_pkg: mode encodings (MODE_ROL=0, MODE_ROR=1, MODE_BOUNCE=2, MODE_HOLD=3) and the pattern() function.
- Sub-module tick_gen (params CLK_HZ, TICK_HZ; ports clk, rst, en, tick) holds the divider counter, width $clog2(DIV).
- led_pattern_engine holds the position/direction FSM and the led register.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=4, ACTIVE_LOW=1.
1. Reset: rst=1 for 2 cycles -> led=4'b1110, pos=0, dir=0, tick=0. With en=1, the first tick comes 10 cycles after rst deasserts.
2. mode 0, en=1, 5 ticks -> pos sequence 1,2,3,0,1; led 1101,1011,0111,1110,1101. Each tick is exactly 1 cycle wide, 10 cycles apart.
3. mode 2 from pos=0, 8 ticks -> pos 1,2,3,2,1,0,1,2; dir goes to 1 at the step into pos 2 after 3 and back to 0 at the step into 1 after 0.
4. mode 1 from pos=0, 2 ticks -> pos 3,2, dir=1. Switch to mode 2 mid-period -> next steps 1,0,1.
5. pause=1 across 2 ticks -> tick pulses still seen, pos/led unchanged. en=0 for 25 cycles -> no ticks; after en=1, first tick at +10 cycles.
6. rst asserted at cnt=7 in mode 0 with pos=2 -> pos=0, led=1110. The next tick comes 10 cycles after release, not 3.
